// File: rtl/pkt_scheduler.sv
// Round-robin TS packet scheduler.
// Four reclocked channel buffers share one byte-serial output. The scheduler
// grants one channel per packet and reads exactly PKT_LEN bytes from it. When
// nothing is eligible it can emit a null packet instead, so the output rate
// stays constant. A fixed gap of idle cycles separates consecutive packets.
module pkt_scheduler #(
    parameter int PKT_LEN = 188,
    parameter int GAP     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  CH_ENABLE,
    input  logic        NULL_INSERT,
    input  logic [3:0]  GOT_FULL_PACKET,
    input  logic [31:0] DATA_IN,
    output logic [3:0]  RD_REQ,
    output logic [7:0]  DATA_OUT,
    output logic        D_VALID_OUT,
    output logic        P_SYNC_OUT,
    output logic [2:0]  CUR_CH,
    output logic [63:0] PKT_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_NULL,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
    localparam logic [2:0] CH_NULL   = 3'd4;
    localparam logic [2:0] CH_IDLE   = 3'd7;

    state_t      state;
    logic [7:0]  byte_cnt;
    logic [7:0]  wait_cnt;
    logic [1:0]  rr_ptr;
    logic [1:0]  cur_sel;
    logic [63:0] pkt_cnt;

    logic [3:0]  eligible;
    logic [1:0]  pick;
    logic        decide;

    logic        vld_p1;
    logic        sop_p1;
    logic        null_p1;
    logic [1:0]  sel_p1;
    logic [7:0]  nbyte_p1;

    // First requesting channel at or after ptr, searching cyclically.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
        return ptr + off;
    endfunction

    // Null packet: sync 0x47, PID 0x1FFF, payload-only with CC 0, then stuffing.
    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        case (idx)
            8'd0:    return 8'h47;
            8'd1:    return 8'h1F;
            8'd2:    return 8'hFF;
            8'd3:    return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] chan_byte(input logic [31:0] d, input logic [1:0] s);
        return d[{s, 3'b000} +: 8];
    endfunction

    // Arbitration inputs and the cycle on which the next packet is chosen.
    // The choice is taken on the last gap cycle (or the last drain cycle when
    // there is no gap) so that the two-cycle read latency overlaps nothing
    // else and packets are spaced by exactly 2+GAP invalid cycles.
    always_comb begin
        eligible = GOT_FULL_PACKET & CH_ENABLE;
        pick     = rr_pick(eligible, rr_ptr);
        decide   = 1'b0;
        case (state)
            ST_IDLE:  decide = 1'b1;
            ST_GAP:   decide = (wait_cnt == GAP_LAST);
            ST_DRAIN: decide = (GAP == 0) && (wait_cnt == 8'd1);
            default:  decide = 1'b0;
        endcase
    end

    // Control FSM: packet sequencing, read strobes, RR pointer and counters.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            byte_cnt <= 8'd0;
            wait_cnt <= 8'd0;
            rr_ptr   <= 2'd0;
            cur_sel  <= 2'd0;
            RD_REQ   <= 4'd0;
            CUR_CH   <= CH_IDLE;
            pkt_cnt  <= 64'd0;
        end else begin
            case (state)
                ST_READ, ST_NULL: begin
                    if (byte_cnt == LAST_BYTE) begin
                        RD_REQ   <= 4'd0;
                        state    <= ST_DRAIN;
                        wait_cnt <= 8'd0;
                        byte_cnt <= 8'd0;
                        if (state == ST_READ) begin
                            rr_ptr <= cur_sel + 2'd1;
                            pkt_cnt[{cur_sel, 4'd0} +: 16] <= pkt_cnt[{cur_sel, 4'd0} +: 16] + 16'd1;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (wait_cnt == 8'd1) begin
                        state    <= (GAP == 0) ? ST_IDLE : ST_GAP;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                default: ;
            endcase

            if (decide) begin
                byte_cnt <= 8'd0;
                wait_cnt <= 8'd0;
                if (eligible != 4'd0) begin
                    state   <= ST_READ;
                    cur_sel <= pick;
                    RD_REQ  <= 4'b0001 << pick;
                    CUR_CH  <= {1'b0, pick};
                end else if (NULL_INSERT) begin
                    state  <= ST_NULL;
                    CUR_CH <= CH_NULL;
                end else begin
                    state  <= ST_IDLE;
                    CUR_CH <= CH_IDLE;
                end
            end
        end
    end

    // ---- stage p1: buffer read in flight, note packet position and source ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p1  <= 1'b0;
            sop_p1  <= 1'b0;
            null_p1 <= 1'b0;
        end else begin
            vld_p1  <= (state == ST_READ) || (state == ST_NULL);
            sop_p1  <= ((state == ST_READ) || (state == ST_NULL)) && (byte_cnt == 8'd0);
            null_p1 <= (state == ST_NULL);
        end
    end

    // Stage p1 data side: channel select and the locally generated null byte.
    always_ff @(posedge CLK) begin
        sel_p1   <= cur_sel;
        nbyte_p1 <= null_byte(byte_cnt);
    end

    // ---- output stage: register the selected byte with its valid/sync flags ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DATA_OUT    <= 8'd0;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
        end else begin
            D_VALID_OUT <= vld_p1;
            P_SYNC_OUT  <= sop_p1;
            if (vld_p1) begin
                DATA_OUT <= null_p1 ? nbyte_p1 : chan_byte(DATA_IN, sel_p1);
            end else begin
                DATA_OUT <= 8'd0;
            end
        end
    end

    assign PKT_CNT = pkt_cnt;

endmodule

// File: tb/tb_pkt_scheduler.sv
// Scoreboard bench for pkt_scheduler: directed scenarios push the expected
// output bytes into a queue; a monitor pops and compares on every valid byte.
module tb_pkt_scheduler;

    localparam int PKT_LEN = 188;

    logic        CLK;
    logic        RST;
    logic [3:0]  CH_ENABLE;
    logic        NULL_INSERT;
    logic [3:0]  GOT_FULL_PACKET;
    logic [31:0] DATA_IN;
    logic [3:0]  RD_REQ;
    logic [7:0]  DATA_OUT;
    logic        D_VALID_OUT;
    logic        P_SYNC_OUT;
    logic [2:0]  CUR_CH;
    logic [63:0] PKT_CNT;

    pkt_scheduler #(.PKT_LEN(PKT_LEN), .GAP(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .CH_ENABLE(CH_ENABLE),
        .NULL_INSERT(NULL_INSERT),
        .GOT_FULL_PACKET(GOT_FULL_PACKET),
        .DATA_IN(DATA_IN),
        .RD_REQ(RD_REQ),
        .DATA_OUT(DATA_OUT),
        .D_VALID_OUT(D_VALID_OUT),
        .P_SYNC_OUT(P_SYNC_OUT),
        .CUR_CH(CUR_CH),
        .PKT_CNT(PKT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    int          gap_q[$];
    logic [15:0] cnt_m[4];
    int          burst = 0;
    int          gap = 0;
    bit          have_burst = 0;
    logic [11:0] mon_e;
    logic [3:0]  rd_d;
    int          idx_r[4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Per-channel data scramble so each source is distinguishable; ch2 sends plain index.
    function automatic logic [7:0] key(input int ch);
        case (ch)
            0:       return 8'h80;
            1:       return 8'h40;
            2:       return 8'h00;
            default: return 8'hC0;
        endcase
    endfunction

    function automatic logic [7:0] null_exp(input int i);
        case (i)
            0:       return 8'h47;
            1:       return 8'h1F;
            2:       return 8'hFF;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] cnt_vec();
        return {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]};
    endfunction

    // ch 0-3 = channel packet, 4 = null packet.
    task automatic push_pkt(input int ch);
        logic [7:0] d;
        for (int i = 0; i < PKT_LEN; i++) begin
            d = (ch == 4) ? null_exp(i) : (8'(i) ^ key(ch));
            exp_q.push_back({3'(ch), (i == 0), d});
        end
    endtask

    task automatic wait_drain(output int rd_cycles);
        rd_cycles = 0;
        for (int n = 0; n < 2000; n++) begin
            if (RD_REQ != 4'd0) rd_cycles++;
            if (exp_q.size() == 0 && !D_VALID_OUT && RD_REQ == 4'd0) break;
            tick(1);
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) cnt_m[i] = 16'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_req"},  RD_REQ, 0);
        chk({tag, "_data"},    DATA_OUT, 0);
        chk({tag, "_valid"},   D_VALID_OUT, 0);
        chk({tag, "_sync"},    P_SYNC_OUT, 0);
        chk({tag, "_cur_ch"},  CUR_CH, 7);
        chk({tag, "_pkt_cnt"}, PKT_CNT, 0);
    endtask

    // One packet from a single ready channel; readiness is dropped as soon as the read starts.
    task automatic run_pkt(input logic [3:0] mask, input int ch, input string tag);
        int n, len, vstart, r;
        GOT_FULL_PACKET = mask;
        n = 0;
        while (RD_REQ == 4'd0 && n < 50) begin
            tick(1);
            n++;
        end
        GOT_FULL_PACKET = 4'd0;
        chk({tag, "_rd_req"}, RD_REQ, 4'b0001 << ch);
        chk({tag, "_cur_ch"}, CUR_CH, ch);
        len = 0;
        vstart = -1;
        while (RD_REQ != 4'd0 && len < 400) begin
            if (D_VALID_OUT && vstart < 0) vstart = len;
            len++;
            tick(1);
        end
        chk({tag, "_rd_len"}, len, PKT_LEN);
        chk({tag, "_latency"}, vstart, 2);
        wait_drain(r);
    endtask

    // Channel buffer model: byte i of a burst appears the cycle after the i-th RD_REQ cycle.
    initial begin
        rd_d = 4'd0;
        for (int n = 0; n < 4; n++) idx_r[n] = 0;
        DATA_IN = {4{8'hEE}};
        forever begin
            @(posedge CLK);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (rd_d[n]) begin
                    DATA_IN[8*n +: 8] = 8'(idx_r[n]) ^ key(n);
                    idx_r[n]++;
                end else begin
                    DATA_IN[8*n +: 8] = 8'hEE;
                    idx_r[n] = 0;
                end
            end
            rd_d = RD_REQ;
        end
    end

    // Monitor: pop and compare on every valid byte, track burst and gap lengths.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                burst = 0;
                gap = 0;
                have_burst = 0;
            end else if (D_VALID_OUT) begin
                if (burst == 0 && have_burst) gap_q.push_back(gap);
                gap = 0;
                burst++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got ch=%0d data=%02h, expected no output", CUR_CH, DATA_OUT);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_byte{ch,sync,data}", {CUR_CH, P_SYNC_OUT, DATA_OUT}, mon_e);
                end
            end else begin
                if (burst != 0) begin
                    chk("burst_len", burst, PKT_LEN);
                    have_burst = 1;
                end
                burst = 0;
                gap++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, starts, rdc, vcnt;
        logic [3:0] prev;

        RST = 1'b0;
        CH_ENABLE = 4'd0;
        NULL_INSERT = 1'b0;
        GOT_FULL_PACKET = 4'd0;
        for (int i = 0; i < 4; i++) cnt_m[i] = 16'd0;
        tick(3);
        chk_reset_outputs("reset");
        RST = 1'b1;
        tick(4);
        chk("idle_cur_ch", CUR_CH, 7);
        chk("idle_valid", D_VALID_OUT, 0);

        // Single channel: ch2 sends its byte index.
        CH_ENABLE = 4'hF;
        push_pkt(2);
        run_pkt(4'b0100, 2, "t1");
        cnt_m[2] = cnt_m[2] + 16'd1;
        chk("t1_pkt_cnt", PKT_CNT, cnt_vec());
        chk("t1_cur_ch_after", CUR_CH, 2);
        tick(6);
        chk("t1_cur_ch_idle", CUR_CH, 7);

        // All four continuously ready: strict round robin from ch0.
        do_reset();
        gap_q.delete();
        for (int i = 0; i < 8; i++) push_pkt(i % 4);
        GOT_FULL_PACKET = 4'hF;
        starts = 0;
        prev = 4'd0;
        for (int n = 0; n < 4000 && starts < 8; n++) begin
            tick(1);
            if (RD_REQ != 4'd0 && prev == 4'd0) starts++;
            prev = RD_REQ;
        end
        GOT_FULL_PACKET = 4'd0;
        chk("t2_starts", starts, 8);
        wait_drain(r);
        for (int i = 0; i < 4; i++) cnt_m[i] = 16'd2;
        chk("t2_pkt_cnt", PKT_CNT, cnt_vec());
        chk("t2_gap_count", gap_q.size(), 7);
        foreach (gap_q[i]) chk("t2_gap", gap_q[i], 4);

        // Null insertion when nothing is eligible; switched off once it starts.
        push_pkt(4);
        NULL_INSERT = 1'b1;
        for (int n = 0; n < 50 && CUR_CH != 3'd4; n++) tick(1);
        NULL_INSERT = 1'b0;
        chk("t3_cur_ch", CUR_CH, 4);
        wait_drain(r);
        chk("t3_rd_req_cycles", r, 0);
        chk("t3_pkt_cnt", PKT_CNT, cnt_vec());
        tick(8);
        chk("t3_cur_ch_idle", CUR_CH, 7);
        vcnt = 0;
        for (int n = 0; n < 30; n++) begin
            if (D_VALID_OUT) vcnt++;
            tick(1);
        end
        chk("t3_idle_valid_cycles", vcnt, 0);

        // Enable withdrawn mid-packet: the packet still completes.
        CH_ENABLE = 4'b0001;
        push_pkt(0);
        GOT_FULL_PACKET = 4'hF;
        for (int n = 0; n < 50 && RD_REQ == 4'd0; n++) tick(1);
        chk("t4_rd_req", RD_REQ, 4'b0001);
        rdc = 0;
        for (int n = 0; n < 400 && burst < 50; n++) begin
            if (RD_REQ != 4'd0) rdc++;
            tick(1);
        end
        CH_ENABLE = 4'd0;
        wait_drain(r);
        rdc += r;
        chk("t4_rd_len", rdc, PKT_LEN);
        cnt_m[0] = cnt_m[0] + 16'd1;
        chk("t4_pkt_cnt", PKT_CNT, cnt_vec());
        tick(10);
        chk("t4_cur_ch_idle", CUR_CH, 7);
        chk("t4_idle_valid", D_VALID_OUT, 0);
        GOT_FULL_PACKET = 4'd0;

        // Reset in the middle of a ch1 packet, then ch3 served first.
        CH_ENABLE = 4'hF;
        push_pkt(1);
        GOT_FULL_PACKET = 4'b0010;
        for (int n = 0; n < 50 && RD_REQ == 4'd0; n++) tick(1);
        GOT_FULL_PACKET = 4'd0;
        chk("t5_rd_req", RD_REQ, 4'b0010);
        for (int n = 0; n < 400 && burst < 100; n++) tick(1);
        RST = 1'b0;
        GOT_FULL_PACKET = 4'b1000;
        #1;
        for (int i = 0; i < 4; i++) cnt_m[i] = 16'd0;
        chk_reset_outputs("t5_midreset");
        exp_q.delete();
        tick(2);
        RST = 1'b1;
        push_pkt(3);
        run_pkt(4'b1000, 3, "t5_after");
        cnt_m[3] = 16'd1;
        chk("t5_pkt_cnt", PKT_CNT, cnt_vec());

        // 16-bit counter wrap on ch0.
        force dut.pkt_cnt = 64'h0001_0000_0000_FFFF;
        #1;
        release dut.pkt_cnt;
        cnt_m[0] = 16'hFFFF;
        tick(1);
        push_pkt(0);
        run_pkt(4'b0001, 0, "t6");
        cnt_m[0] = cnt_m[0] + 16'd1;
        chk("t6_pkt_cnt_wrap", PKT_CNT, cnt_vec());

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_scheduler.md
Name: pkt_scheduler

Overview:
- Round-robin packet scheduler that shares the single 54 MHz output path between four reclocked TS input channels.
- Each input buffer flags when it holds a full 188-byte packet. The scheduler grants one channel at a time, reads exactly one packet, and drives a byte-serial TS stream with valid and packet-sync markers.
- When no enabled channel is ready, it optionally emits internally generated null packets to keep the output rate constant.
- It sits between the per-channel reclock buffers and the output FIFO. Software configures it through CH_ENABLE and NULL_INSERT.

Parameters:
- PKT_LEN, 188, bytes per TS packet; 8-bit internal byte counter.
- GAP, 2, idle cycles (D_VALID_OUT=0) inserted after every packet; 0 is legal.

Ports:
- CLK  in  1  system clock (sys_clk)
- RST  in  1  asynchronous reset, active low
- CH_ENABLE  in  4  per-channel enable mask
- NULL_INSERT  in  1  1 = emit null packet when nothing is eligible
- GOT_FULL_PACKET  in  4  channel buffer holds at least one full packet
- DATA_IN  in  32  channel data, ch n on [8n+7:8n]; valid 1 cycle after its RD_REQ
- RD_REQ  out  4  one-hot read strobe to channel buffers, held PKT_LEN cycles
- DATA_OUT  out  8  output TS byte
- D_VALID_OUT  out  1  DATA_OUT valid
- P_SYNC_OUT  out  1  high on byte 0 (0x47 position) of every packet
- CUR_CH  out  3  source of current packet: 0-3 = channel, 4 = null, 7 = idle
- PKT_CNT  out  64  per-channel packets-sent counters, ch n on [16n+15:16n]

Behaviour:
- Reset (RST=0, asynchronous):
  - RD_REQ=0, DATA_OUT=0, D_VALID_OUT=0, P_SYNC_OUT=0, CUR_CH=7, PKT_CNT=0.
  - RR pointer = ch0; state IDLE.
  - Reset mid-packet aborts immediately, with no completion of the packet.
- Eligible = GOT_FULL_PACKET & CH_ENABLE, sampled in IDLE only.
- States:
  - IDLE:
    - eligible != 0 → choose the first set bit at or after the RR pointer, cyclically. Go to READ with RD_REQ one-hot asserted in the next cycle and CUR_CH = chosen channel.
    - Else if NULL_INSERT=1 → go to NULL, CUR_CH=4.
    - Else stay in IDLE, CUR_CH=7.
  - READ:
    - RD_REQ[ch] is high for exactly PKT_LEN consecutive cycles; byte counter runs 0..PKT_LEN-1.
    - Data path: DATA_IN slice of ch registered to DATA_OUT. D_VALID_OUT is RD_REQ delayed by 2 cycles (1 buffer latency + 1 output register).
    - P_SYNC_OUT aligns with the first valid byte.
    - After the last RD_REQ cycle, go to DRAIN.
  - NULL:
    - Generate PKT_LEN bytes on the same output timing as READ: 0x47, 0x1F, 0xFF, 0x10, then 0xFF × 184.
    - D_VALID_OUT and P_SYNC_OUT as in READ. No RD_REQ asserted.
  - DRAIN: wait 2 cycles for the pipeline to empty, then go to GAP (or IDLE if GAP=0).
  - GAP: GAP cycles with D_VALID_OUT=0, then go to IDLE.
- Arbitration bookkeeping:
  - On completion of a channel packet, RR pointer = served ch + 1 (mod 4) and PKT_CNT[ch] += 1, wrapping at 16 bits (0xFFFF → 0).
  - Null packets advance neither the pointer nor any counter.
- Boundary conditions:
  - CH_ENABLE or NULL_INSERT changes mid-packet: the current packet completes unchanged; the new value takes effect at the next IDLE decision.
  - GOT_FULL_PACKET dropping mid-READ is ignored; the buffer guarantees the data.
  - Several channels ready simultaneously: strict RR; each of 4 continuously ready channels is served once per 4 packets.
  - D_VALID_OUT bursts are exactly PKT_LEN long. There is never a partial packet, except on reset.
  - Minimum inter-packet spacing is 2+GAP invalid cycles.

Test Plan:
- Reset, CH_ENABLE=4'hF, GOT_FULL_PACKET=4'b0100, ch2 data = byte index → RD_REQ=4'b0100 for 188 cycles. D_VALID_OUT for 188 cycles starting 2 cycles after the first RD_REQ; DATA_OUT 0..187; P_SYNC_OUT on byte 0; PKT_CNT[2]=1; CUR_CH=2.
- All four channels ready continuously for 8 packets → CUR_CH order 0,1,2,3,0,1,2,3; each PKT_CNT=2; gaps of 4 invalid cycles (GAP=2).
- GOT_FULL_PACKET=0, NULL_INSERT=1 → null packet 47 1F FF 10 FF… (188 bytes), CUR_CH=4, RD_REQ=0, counters unchanged. With NULL_INSERT=0 → D_VALID_OUT stays 0, CUR_CH=7.
- CH_ENABLE=4'b0001 with all ready; clear CH_ENABLE[0] at byte 50 → ch0 packet completes (188 bytes), next decision selects null or idle.
- RST low at byte 100 of a ch1 packet → all outputs 0 on the same cycle, CUR_CH=7. After release with ch3 ready, ch3 is served first (pointer reset to 0, ch0-2 not ready).
- Preload PKT_CNT[0] to 0xFFFF by sending 65535 ch0 packets (or force) → one more packet reads 0x0000.
